hnf_pcrd_grant_sched: RTL

- Schedules CHI PCrdGrant responses at the HN-F for RN-F requesters that received a RetryAck.
- Tracks one pending-retry bit per requester slot and counts protocol credits released by the MSHR.
- Grants credits to pending slots round-robin, starting after the last granted slot, through a valid/ready handshake to the TXRSP path.
- Sits beside hnf_mshr_qos: qos sets pending bits and returns credits; this block drives the PCrdGrant request.

---
 rtl/hnf_pcrd_grant_sched.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/hnf_pcrd_grant_sched.sv
// ----------------------------------------------------------------------------
// hnf_pcrd_grant_sched
//
// PCrdGrant scheduler for the HN-F. Requesters that were sent a RetryAck are
// marked pending here; credits released by the MSHR are counted; one credit
// at a time is granted to a pending requester, round-robin starting just
// after the previously granted slot, through a valid/ready handshake toward
// the TXRSP path.
//
// Ports:
//   clk             clock
//   rst             asynchronous, active-high reset
//   retry_set_vec   per-slot one-cycle pulses marking a slot as retried
//   crd_free        one-cycle pulse, one MSHR credit released
//   pcrd_ready      TXRSP accepts the current PCrdGrant
//   pcrd_valid      PCrdGrant request valid
//   pcrd_entry_ptr  one-hot slot being granted (zero when no grant is held)
//   pend_vec        registered pending-retry bits
//   crd_cnt         registered count of available credits
//   crd_ovf_err     sticky: a credit arrived while the counter was full
// ----------------------------------------------------------------------------
module hnf_pcrd_grant_sched #(
    parameter int HNF_MSHR_RNF_NUM_PARAM = 4,
    parameter int CRD_CNT_WIDTH          = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [HNF_MSHR_RNF_NUM_PARAM-1:0] retry_set_vec,
    input  logic                              crd_free,
    input  logic                              pcrd_ready,
    output logic                              pcrd_valid,
    output logic [HNF_MSHR_RNF_NUM_PARAM-1:0] pcrd_entry_ptr,
    output logic [HNF_MSHR_RNF_NUM_PARAM-1:0] pend_vec,
    output logic [CRD_CNT_WIDTH-1:0]          crd_cnt,
    output logic                              crd_ovf_err
);

    localparam int ENTRIES_NUM = HNF_MSHR_RNF_NUM_PARAM;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SEL   = 2'd1;
    localparam logic [1:0] ST_GRANT = 2'd2;

    localparam logic [CRD_CNT_WIDTH-1:0] MAX_CRD = '1;

    logic [1:0]             state;
    logic [1:0]             state_nxt;
    logic [ENTRIES_NUM-1:0] start_mask;
    logic [ENTRIES_NUM-1:0] masked_vec;
    logic [ENTRIES_NUM-1:0] sel_src;
    logic [ENTRIES_NUM-1:0] sel_onehot;
    logic [ENTRIES_NUM-1:0] above_mask;
    logic                   have_work;
    logic                   handshake;

    // A grant may be started only with at least one pending slot and credit.
    assign have_work  = (pend_vec != '0) && (crd_cnt != '0);
    assign pcrd_valid = (state == ST_GRANT);
    assign handshake  = pcrd_valid && pcrd_ready;

    // Round-robin pick: prefer pending slots above the last grant, otherwise
    // wrap to the lowest pending slot.
    always_comb begin
        logic found;
        masked_vec = pend_vec & start_mask;
        sel_src    = (masked_vec != '0) ? masked_vec : pend_vec;
        sel_onehot = '0;
        found      = 1'b0;
        for (int unsigned i = 0; i < ENTRIES_NUM; i++) begin
            if (sel_src[i] && !found) begin
                sel_onehot[i] = 1'b1;
                found         = 1'b1;
            end
        end
    end

    // Bits strictly above the slot currently being granted; empty when the
    // top slot is granted, which makes the next pick start from slot 0.
    always_comb begin
        logic seen;
        above_mask = '0;
        seen       = 1'b0;
        for (int unsigned i = 0; i < ENTRIES_NUM; i++) begin
            above_mask[i] = seen;
            if (pcrd_entry_ptr[i]) begin
                seen = 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (have_work) begin
                    state_nxt = ST_SEL;
                end
            end
            ST_SEL: begin
                state_nxt = have_work ? ST_GRANT : ST_IDLE;
            end
            ST_GRANT: begin
                if (handshake) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Pointer is loaded in SEL and held through backpressure until accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pcrd_entry_ptr <= '0;
        end else if (state == ST_SEL && have_work) begin
            pcrd_entry_ptr <= sel_onehot;
        end else if (handshake) begin
            pcrd_entry_ptr <= '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            start_mask <= '0;
        end else if (handshake) begin
            start_mask <= above_mask;
        end
    end

    // A new retry on the slot being granted in the same cycle wins, so the
    // set term is applied after the clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_vec <= '0;
        end else begin
            pend_vec <= (pend_vec & ~(handshake ? pcrd_entry_ptr : '0)) | retry_set_vec;
        end
    end

    // Simultaneous release and grant cancel out; a release into a full
    // counter saturates and is flagged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            crd_cnt     <= '0;
            crd_ovf_err <= 1'b0;
        end else begin
            case ({crd_free, handshake})
                2'b10: begin
                    if (crd_cnt == MAX_CRD) begin
                        crd_ovf_err <= 1'b1;
                    end else begin
                        crd_cnt <= crd_cnt + 1'b1;
                    end
                end
                2'b01: crd_cnt <= crd_cnt - 1'b1;
                default: ;
            endcase
        end
    end

endmodule
